// File: rtl/clock_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// clock_ctrl_pkg
// Shared types and constants for the clock time-set controller.
//   ctrl_state_e   : controller FSM state (3 bits)
//   HOUR_*/MIN_*   : field widths and legal ranges of the 12-hour display
//   hour/min wrap  : helpers that step a field with wrap-around
// -----------------------------------------------------------------------------
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff     = 3'd0,
        StRunning = 3'd1,
        StStopped = 3'd2,
        StSetHour = 3'd3,
        StSetMin  = 3'd4,
        StCommit  = 3'd5
    } ctrl_state_e;

    localparam int unsigned HOUR_W = 5;
    localparam int unsigned MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MIN = 5'd1;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd12;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    // Out-of-range values (0 or >12) are folded back into 1..12.
    function automatic logic [HOUR_W-1:0] hour_wrap_inc(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_MAX) ? HOUR_MIN : h + HOUR_W'(1);
    endfunction

    function automatic logic [HOUR_W-1:0] hour_wrap_dec(input logic [HOUR_W-1:0] h);
        return (h <= HOUR_MIN || h > HOUR_MAX) ? HOUR_MAX : h - HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] min_wrap_inc(input logic [MIN_W-1:0] m);
        return (m >= MIN_MAX) ? '0 : m + MIN_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] min_wrap_dec(input logic [MIN_W-1:0] m);
        return (m == '0 || m > MIN_MAX) ? MIN_MAX : m - MIN_W'(1);
    endfunction

endpackage

// File: rtl/clock_tick_div.sv
// -----------------------------------------------------------------------------
// clock_tick_div
// Free-running divider producing a one-cycle tick every CLK_FRQ/RATE_HZ enabled
// clock cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the period (count back to zero), overrides en
//   en         : count enable
//   tick       : high on the last cycle of each period
// -----------------------------------------------------------------------------
module clock_tick_div #(
    parameter int unsigned CLK_FRQ = 100000000,
    parameter int unsigned RATE_HZ = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned Period = (CLK_FRQ / RATE_HZ > 0) ? CLK_FRQ / RATE_HZ : 1;
    localparam int unsigned CntW   = (Period > 1) ? $clog2(Period) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(Period - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == CntLast) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

    assign tick = en && !clr && (r_cnt == CntLast);

endmodule

// File: rtl/clock_set_controller.sv
// -----------------------------------------------------------------------------
// clock_set_controller
// Button front-end for the 12-hour clock core: run/stop pulses, and the
// hour -> minute -> commit time-set sequence with a shadow copy of the time.
// Optional feature macro: CLK_SET_TIMEOUT_EN (auto-commit after TIMEOUT_SEC
// seconds without a button while setting).
//   clk, rst_n                      : clock, asynchronous active-low reset
//   btn_run/mode/up/down            : single-cycle debounced button pulses
//   cur_hour, cur_minute            : live time from the core
//   clk_start, clk_stop             : single-cycle pulses to the core
//   clk_edit                        : edit level; core copies e_hour/e_minute
//   e_hour, e_minute                : shadow time being edited
//   sel_hour, sel_min               : field being edited
//   blink                           : display blank-enable
// -----------------------------------------------------------------------------
module clock_set_controller
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FRQ     = 100000000,
    parameter int unsigned BLINK_HZ    = 2,
    parameter int unsigned TIMEOUT_SEC = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_run,
    input  logic              btn_mode,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_minute,
    output logic              clk_start,
    output logic              clk_stop,
    output logic              clk_edit,
    output logic [HOUR_W-1:0] e_hour,
    output logic [MIN_W-1:0]  e_minute,
    output logic              sel_hour,
    output logic              sel_min,
    output logic              blink
);

    if (TIMEOUT_SEC == 0) begin : g_bad_timeout
        $error("TIMEOUT_SEC must be at least 1");
    end
    if (CLK_FRQ < 2 * BLINK_HZ || BLINK_HZ == 0) begin : g_bad_blink
        $error("CLK_FRQ must be at least 2*BLINK_HZ and BLINK_HZ nonzero");
    end

    ctrl_state_e r_state, w_state_d;

    logic              r_clk_start, r_clk_stop, r_clk_edit, r_sel_hour, r_sel_min, r_blink;
    logic [HOUR_W-1:0] r_e_hour;
    logic [MIN_W-1:0]  r_e_minute;

    logic              w_clk_start_d, w_clk_stop_d, w_clk_edit_d;
    logic              w_sel_hour_d, w_sel_min_d, w_blink_d;
    logic [HOUR_W-1:0] w_e_hour_d;
    logic [MIN_W-1:0]  w_e_minute_d;

    logic w_in_set_q, w_in_set_d, w_enter_set, w_blink_tick, w_timeout;
    logic w_up, w_down;

    assign w_in_set_q  = (r_state == StSetHour) || (r_state == StSetMin);
    assign w_in_set_d  = (w_state_d == StSetHour) || (w_state_d == StSetMin);
    // Any move into a SET_* state (including hour -> minute) restarts blinking.
    assign w_enter_set = w_in_set_d && (w_state_d != r_state);
    // Simultaneous up and down cancel out.
    assign w_up        = btn_up && !btn_down;
    assign w_down      = btn_down && !btn_up;

    clock_tick_div #(
        .CLK_FRQ (CLK_FRQ),
        .RATE_HZ (2 * BLINK_HZ)
    ) u_blink_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_enter_set),
        .en    (w_in_set_q),
        .tick  (w_blink_tick)
    );

`ifdef CLK_SET_TIMEOUT_EN
    localparam int unsigned IdleW = $clog2(TIMEOUT_SEC + 1);

    logic             w_any_btn, w_idle_clr, w_sec_tick;
    logic [IdleW-1:0] r_idle_sec;

    assign w_any_btn  = btn_run || btn_mode || btn_up || btn_down;
    // Entry into SET_* always comes from a non-set state or a button, so this
    // also restarts the count on entry without looping through w_state_d.
    assign w_idle_clr = w_any_btn || !w_in_set_q;

    clock_tick_div #(
        .CLK_FRQ (CLK_FRQ),
        .RATE_HZ (1)
    ) u_sec_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_idle_clr),
        .en    (w_in_set_q),
        .tick  (w_sec_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idle_sec <= '0;
        end else if (w_idle_clr) begin
            r_idle_sec <= '0;
        end else if (w_sec_tick) begin
            r_idle_sec <= r_idle_sec + IdleW'(1);
        end
    end

    assign w_timeout = w_sec_tick && (r_idle_sec == IdleW'(TIMEOUT_SEC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StOff;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next state; run > mode > up > down
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StOff, StStopped: begin
                if (btn_run)       w_state_d = StRunning;
                else if (btn_mode) w_state_d = StSetHour;
            end
            StRunning: begin
                if (btn_run)       w_state_d = StStopped;
                else if (btn_mode) w_state_d = StSetHour;
            end
            StSetHour: begin
                if (btn_run)        w_state_d = StCommit;
                else if (btn_mode)  w_state_d = StSetMin;
                else if (w_timeout) w_state_d = StCommit;
            end
            StSetMin: begin
                if (btn_run || btn_mode || w_timeout) w_state_d = StCommit;
            end
            StCommit: w_state_d = StRunning;
            default:  w_state_d = StOff;
        endcase
    end

    // Next output values, registered below
    always_comb begin
        w_clk_start_d = ((w_state_d == StRunning) && ((r_state == StOff) || (r_state == StStopped)))
                        || (w_state_d == StCommit);
        w_clk_stop_d  = (r_state == StRunning) && (w_state_d == StStopped);
        w_clk_edit_d  = w_in_set_d || (w_state_d == StCommit);
        w_sel_hour_d  = (w_state_d == StSetHour);
        w_sel_min_d   = (w_state_d == StSetMin);

        w_e_hour_d   = r_e_hour;
        w_e_minute_d = r_e_minute;
        if (!w_in_set_q && !(r_state == StCommit) && (w_state_d == StSetHour)) begin
            w_e_hour_d   = (cur_hour == '0) ? HOUR_MAX : cur_hour;
            w_e_minute_d = cur_minute;
        end else if ((r_state == StSetHour) && (w_state_d == StSetHour)) begin
            if (w_up)        w_e_hour_d = hour_wrap_inc(r_e_hour);
            else if (w_down) w_e_hour_d = hour_wrap_dec(r_e_hour);
        end else if ((r_state == StSetMin) && (w_state_d == StSetMin)) begin
            if (w_up)        w_e_minute_d = min_wrap_inc(r_e_minute);
            else if (w_down) w_e_minute_d = min_wrap_dec(r_e_minute);
        end

        if (!w_in_set_d)       w_blink_d = 1'b1;
        else if (w_enter_set)  w_blink_d = 1'b0;
        else if (w_blink_tick) w_blink_d = ~r_blink;
        else                   w_blink_d = r_blink;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_start <= 1'b0;
            r_clk_stop  <= 1'b0;
            r_clk_edit  <= 1'b0;
            r_e_hour    <= HOUR_MAX;
            r_e_minute  <= '0;
            r_sel_hour  <= 1'b0;
            r_sel_min   <= 1'b0;
            r_blink     <= 1'b1;
        end else begin
            r_clk_start <= w_clk_start_d;
            r_clk_stop  <= w_clk_stop_d;
            r_clk_edit  <= w_clk_edit_d;
            r_e_hour    <= w_e_hour_d;
            r_e_minute  <= w_e_minute_d;
            r_sel_hour  <= w_sel_hour_d;
            r_sel_min   <= w_sel_min_d;
            r_blink     <= w_blink_d;
        end
    end

    assign clk_start = r_clk_start;
    assign clk_stop  = r_clk_stop;
    assign clk_edit  = r_clk_edit;
    assign e_hour    = r_e_hour;
    assign e_minute  = r_e_minute;
    assign sel_hour  = r_sel_hour;
    assign sel_min   = r_sel_min;
    assign blink     = r_blink;

endmodule
